// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first, REP times,
// with GAP idle bits between repeats. All outputs are registered.
module serial_pattern_gen #(
   parameter int PAT_W = 4,
   parameter int GAP   = 1,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [REP_W-1:0] rep_cnt,
   input  logic             abort,
   output logic             serout,
   output logic             ser_valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       ps
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int BW = $clog2(PAT_W);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int BL = PAT_W - 1;
   localparam int GL = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [BW-1:0] BLAST = BL[BW-1:0];
   localparam logic [GW-1:0] GLAST = GL[GW-1:0];

   logic [PAT_W-1:0] shreg;
   logic [PAT_W-1:0] pat;
   logic [REP_W-1:0] rcnt;
   logic [BW-1:0]    bcnt;
   logic [GW-1:0]    gcnt;

   // Outputs are a registered view of the state, so they trail ps by one edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps        <= S_IDLE;
         serout    <= 1'b0;
         ser_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         shreg     <= '0;
         pat       <= '0;
         rcnt      <= '0;
         bcnt      <= '0;
         gcnt      <= '0;
      end else begin
         done <= 1'b0;
         if (abort && ps != S_IDLE) begin
            ps        <= S_IDLE;
            serout    <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            busy      <= (ps != S_IDLE);
            serout    <= 1'b0;
            ser_valid <= 1'b0;
            unique case (ps)
               S_IDLE: begin
                  if (start) begin
                     shreg <= pattern;
                     pat   <= pattern;
                     rcnt  <= rep_cnt;
                     bcnt  <= '0;
                     gcnt  <= '0;
                     ps    <= (rep_cnt == '0) ? S_DONE : S_SEND;
                  end
               end
               S_SEND: begin
                  serout    <= shreg[PAT_W-1];
                  ser_valid <= 1'b1;
                  shreg     <= {shreg[PAT_W-2:0], 1'b0};
                  if (bcnt == BLAST) begin
                     bcnt <= '0;
                     if (rcnt > REP_W'(1)) begin
                        rcnt  <= rcnt - REP_W'(1);
                        shreg <= pat;
                        gcnt  <= '0;
                        ps    <= (GAP > 0) ? S_GAP : S_SEND;
                     end else begin
                        ps <= S_DONE;
                     end
                  end else begin
                     bcnt <= bcnt + BW'(1);
                  end
               end
               S_GAP: begin
                  if (gcnt == GLAST) begin
                     ps <= S_SEND;
                  end else begin
                     gcnt <= gcnt + GW'(1);
                  end
               end
               S_DONE: begin
                  done <= 1'b1;
                  ps   <= S_IDLE;
               end
               default: ps <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: GAP=1 instance plus a GAP=0 instance.
// Observed vector per cycle is {busy, done, ser_valid, serout}.
module tb_serial_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       start0;
   logic       abort;
   logic [3:0] pattern;
   logic [3:0] rep_cnt;

   logic       serout, ser_valid, busy, done;
   logic [1:0] ps;
   logic       serout0, ser_valid0, busy0, done0;
   logic [1:0] ps0;

   logic [3:0] ob;
   logic [3:0] ob0;

   int errors = 0;
   int checks = 0;

   assign ob  = {busy, done, ser_valid, serout};
   assign ob0 = {busy0, done0, ser_valid0, serout0};

   always #5 clk = ~clk;

   serial_pattern_gen #(.PAT_W(4), .GAP(1), .REP_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern),
      .rep_cnt(rep_cnt), .abort(abort), .serout(serout),
      .ser_valid(ser_valid), .busy(busy), .done(done), .ps(ps)
   );

   serial_pattern_gen #(.PAT_W(4), .GAP(0), .REP_W(4)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .pattern(pattern),
      .rep_cnt(rep_cnt), .abort(abort), .serout(serout0),
      .ser_valid(ser_valid0), .busy(busy0), .done(done0), .ps(ps0)
   );

   task automatic launch(input logic [3:0] p, input logic [3:0] r);
      pattern = p;
      rep_cnt = r;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ob !== 4'b0000) begin
         errors++;
         $display("FAIL reset_out got %b want 0000", ob);
      end
      checks++;
      if (ps !== 2'd0) begin
         errors++;
         $display("FAIL reset_ps got %0d want 0", ps);
      end
      checks++;
      if (ob0 !== 4'b0000 || ps0 !== 2'd0) begin
         errors++;
         $display("FAIL reset_gap0 got %b/%0d want 0000/0", ob0, ps0);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [3:0] want [6];
      want = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
      launch(4'b1011, 4'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checks++;
         if (ob !== want[k]) begin
            errors++;
            $display("FAIL single k=%0d got %b want %b", k + 1, ob, want[k]);
         end
      end
   endtask

   task automatic test_repeat_gap(input bit noise);
      logic [3:0] want [11];
      want = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1000,
               4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
      launch(4'b1011, 4'd2);
      for (int k = 0; k < 11; k++) begin
         @(posedge clk); #1;
         checks++;
         if (ob !== want[k]) begin
            errors++;
            $display("FAIL repeat noise=%0d k=%0d got %b want %b",
                     noise, k + 1, ob, want[k]);
         end
         if (noise && k < 8) begin
            start   = ~start;
            pattern = ~pattern;
            rep_cnt = 4'(k);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_no_gap();
      logic [11:0] bits;
      logic [3:0]  w;
      bits    = 12'b110011001100;
      pattern = 4'b1100;
      rep_cnt = 4'd3;
      start0  = 1'b1;
      @(posedge clk); #1;
      start0  = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         if (k < 12) w = {3'b101, bits[11-k]};
         else if (k == 12) w = 4'b1100;
         else w = 4'b0000;
         checks++;
         if (ob0 !== w) begin
            errors++;
            $display("FAIL no_gap k=%0d got %b want %b", k + 1, ob0, w);
         end
      end
   endtask

   task automatic test_zero_rep();
      logic [3:0] want [4];
      want = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
      launch(4'b1111, 4'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (ob !== want[k]) begin
            errors++;
            $display("FAIL zero_rep k=%0d got %b want %b", k + 1, ob, want[k]);
         end
      end
   endtask

   task automatic test_abort();
      logic [3:0] want [3];
      int bad;
      want = '{4'b1011, 4'b1010, 4'b1011};
      launch(4'b1011, 4'd2);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++;
         if (ob !== want[k]) begin
            errors++;
            $display("FAIL abort_pre k=%0d got %b want %b", k + 1, ob, want[k]);
         end
      end
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      checks++;
      if (ob !== 4'b0000 || ps !== 2'd0) begin
         errors++;
         $display("FAIL abort_idle got %b/%0d want 0000/0", ob, ps);
      end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (ob !== 4'b0000) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL abort_quiet got %0d active cycles want 0", bad);
      end
   endtask

   task automatic test_abort_in_idle();
      abort = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (ob !== 4'b0000 || ps !== 2'd0) begin
         errors++;
         $display("FAIL abort_in_idle got %b/%0d want 0000/0", ob, ps);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] want [6];
      want = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
      launch(4'b1011, 4'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (ob !== 4'b1010) begin
         errors++;
         $display("FAIL rst_mid_pre got %b want 1010", ob);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (ob !== 4'b0000 || ps !== 2'd0) begin
         errors++;
         $display("FAIL rst_mid_async got %b/%0d want 0000/0", ob, ps);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      launch(4'b1011, 4'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checks++;
         if (ob !== want[k]) begin
            errors++;
            $display("FAIL rst_mid_after k=%0d got %b want %b", k + 1, ob, want[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] want [12];
      want = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000,
               4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
      pattern = 4'b1011;
      rep_cnt = 4'd1;
      start   = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (k == 5) start = 1'b0;
         checks++;
         if (ob !== want[k]) begin
            errors++;
            $display("FAIL b2b k=%0d got %b want %b", k + 1, ob, want[k]);
         end
      end
   endtask

   task automatic test_max_rep();
      logic [3:0] p;
      int nvalid;
      int done_at;
      int badbit;
      p       = 4'b1001;
      nvalid  = 0;
      done_at = 0;
      badbit  = 0;
      launch(p, 4'hF);
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (ser_valid === 1'b1) begin
            if (serout !== p[3 - (nvalid % 4)]) badbit++;
            nvalid++;
         end
         if (done === 1'b1) begin
            done_at = k;
            break;
         end
      end
      @(posedge clk); #1;
      checks++;
      if (done_at != 75) begin
         errors++;
         $display("FAIL max_done got cycle %0d want 75", done_at);
      end
      checks++;
      if (nvalid != 60) begin
         errors++;
         $display("FAIL max_bits got %0d want 60", nvalid);
      end
      checks++;
      if (badbit != 0) begin
         errors++;
         $display("FAIL max_data got %0d wrong bits want 0", badbit);
      end
      checks++;
      if (ob !== 4'b0000) begin
         errors++;
         $display("FAIL max_idle got %b want 0000", ob);
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      start0  = 1'b0;
      abort   = 1'b0;
      pattern = 4'b0000;
      rep_cnt = 4'd0;
      test_reset();
      test_single();
      test_repeat_gap(1'b0);
      test_repeat_gap(1'b1);
      test_no_gap();
      test_zero_rep();
      test_abort();
      test_abort_in_idle();
      test_reset_mid();
      test_back_to_back();
      test_max_rep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
